sum_operand_packer: RTL and testbench

Front-end feeder for the 8-lane 32-bit adder tree (wallace_tree_sum). It accepts a stream of 32-bit operands over a valid/ready handshake and packs LANES consecutive words into one LANES*WIDTH-bit vector. It zero-pads partial vectors that are terminated by in_last, then presents each vector with out_valid. out_valid/out_data connect directly to the adder's valid_in/data_in; out_ready is tied high in that use.

---
 rtl/sum_pkg.sv | 24 ++
 rtl/sum_operand_packer.sv | 132 +++++++++++++
 tb/tb_sum_operand_packer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sum_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sum_pkg
// Description : Shared constants and state encoding for the adder-tree
//               operand packer.
// Revision    : 1.0 - initial release
// ============================================================================
package sum_pkg;

  localparam int LANES = 8;                    // operands per output vector
  localparam int WIDTH = 32;                   // bits per operand
  localparam int CNT_W = $clog2(LANES + 1);    // width of a 1..LANES count
  localparam int IDX_W = $clog2(LANES);        // width of a 0..LANES-1 lane index
  localparam int VEC_W = LANES * WIDTH;        // packed vector width

  // FILL accepts words; HOLD parks a completed vector while the output
  // register is still occupied.
  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage : sum_pkg
`default_nettype wire

// File: rtl/sum_operand_packer.sv
`default_nettype none
// ============================================================================
// Module      : sum_operand_packer
// Description : Packs a valid/ready stream of WIDTH-bit operands into
//               LANES-wide vectors (first word in the MS lane), zero-padding
//               vectors closed early by in_last, for the wallace_tree_sum.
// Revision    : 1.0 - initial release
// ============================================================================
module sum_operand_packer
  import sum_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VEC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count
);

  // In FILL lane_q is the index of the next lane to write. In HOLD it holds
  // the word count of the parked vector, which still lives in asm_q.
  state_t           state_q,     state_d;
  logic [CNT_W-1:0] lane_q,      lane_d;
  logic [VEC_W-1:0] asm_q,       asm_d;
  logic             out_valid_q, out_valid_d;
  logic [VEC_W-1:0] out_data_q,  out_data_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  logic             w_accept;
  logic             w_complete;
  logic             w_out_free;
  logic [IDX_W-1:0] w_idx;
  logic [VEC_W-1:0] w_vec;

  // in_ready is a pure decode of the state register, so out_ready never
  // reaches it combinationally.
  assign in_ready   = (state_q == FILL);
  assign w_accept   = in_valid && in_ready;
  assign w_idx      = lane_q[IDX_W-1:0];
  assign w_complete = w_accept && (in_last || (lane_q == CNT_W'(LANES - 1)));
  assign w_out_free = !out_valid_q || out_ready;

  // Assembly buffer with the incoming word dropped into the current lane.
  always_comb begin
    w_vec = asm_q;
    for (int i = 0; i < LANES; i++) begin
      if (int'(w_idx) == i) begin
        w_vec[(LANES - 1 - i) * WIDTH +: WIDTH] = in_data;
      end
    end
  end

  // Next-state logic for the lane counter, assembly buffer and output register.
  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    asm_d       = asm_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;

    // A consumed vector retires unless something new loads below.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      FILL: begin
        if (w_accept) begin
          if (w_complete && w_out_free) begin
            out_valid_d = 1'b1;
            out_data_d  = w_vec;
            out_count_d = lane_q + 1'b1;
            asm_d       = '0;
            lane_d      = '0;
          end else if (w_complete) begin
            // Output busy: park the finished vector and stop accepting.
            asm_d   = w_vec;
            lane_d  = lane_q + 1'b1;
            state_d = HOLD;
          end else begin
            asm_d  = w_vec;
            lane_d = lane_q + 1'b1;
          end
        end
      end
      HOLD: begin
        // Entered only with out_valid_q set, so out_ready frees the register.
        if (out_ready) begin
          out_valid_d = 1'b1;
          out_data_d  = asm_q;
          out_count_d = lane_q;
          asm_d       = '0;
          lane_d      = '0;
          state_d     = FILL;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      lane_q      <= '0;
      asm_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      asm_q       <= asm_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

endmodule : sum_operand_packer
`default_nettype wire

// File: tb/tb_sum_operand_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sum_operand_packer
// Description : Scoreboard bench for sum_operand_packer. Accepted words feed
//               a reference packer that queues expected vectors; a monitor
//               pops and compares them on every output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_operand_packer;
  import sum_pkg::*;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [VEC_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [VEC_W-1:0] exp_data_q[$];
  logic [CNT_W-1:0] exp_cnt_q[$];
  logic [WIDTH-1:0] words_q[$];

  sum_operand_packer u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: a handshake seen at the falling edge completes on the
  // following rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_checks = n_checks + 1;
      if (exp_data_q.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL sb_unexpected: got vector %h count %0d, none expected", out_data, out_count);
      end else begin
        logic [VEC_W-1:0] ed;
        logic [CNT_W-1:0] ec;
        ed = exp_data_q.pop_front();
        ec = exp_cnt_q.pop_front();
        if (out_data !== ed) begin
          n_fail = n_fail + 1;
          $display("FAIL sb_data: got %h expected %h", out_data, ed);
        end
        n_checks = n_checks + 1;
        if (out_count !== ec) begin
          n_fail = n_fail + 1;
          $display("FAIL sb_count: got %0d expected %0d", out_count, ec);
        end
      end
    end
  end

  // Reference packing: first word in the MS lane, unused lanes zero.
  task automatic model_push();
    logic [VEC_W-1:0] v;
    int n;
    n = words_q.size();
    v = '0;
    for (int i = 0; i < LANES; i++) begin
      v = v << WIDTH;
      if (i < n) v[WIDTH-1:0] = words_q[i];
    end
    exp_data_q.push_back(v);
    exp_cnt_q.push_back(CNT_W'(n));
    words_q.delete();
  endtask

  // Present one word and hold it until accepted (bounded wait).
  task automatic send_word(input logic [WIDTH-1:0] d, input logic last);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        words_q.push_back(d);
        if (last || words_q.size() == LANES) model_push();
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    n_checks = n_checks + 1;
    if (!acc) begin
      n_fail = n_fail + 1;
      $display("FAIL send_timeout: word %h not accepted, in_ready=%b", d, in_ready);
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 50 && exp_data_q.size() != 0; t++) @(posedge clk);
    #1;
    n_checks = n_checks + 1;
    if (exp_data_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL drain: %0d vectors outstanding, expected 0", exp_data_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks = n_checks + 3;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
    if (out_data !== '0)    begin n_fail++; $display("FAIL rst_data: got %h expected 0", out_data); end
    if (out_count !== '0)   begin n_fail++; $display("FAIL rst_count: got %0d expected 0", out_count); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks = n_checks + 1;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_full_vector();
    logic [VEC_W-1:0] ref_v;
    ref_v = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send_word(WIDTH'(i), 1'b0);
    n_checks = n_checks + 3;
    if (out_valid !== 1'b1)  begin n_fail++; $display("FAIL full_valid: got %b expected 1", out_valid); end
    if (out_data !== ref_v)  begin n_fail++; $display("FAIL full_data: got %h expected %h", out_data, ref_v); end
    if (out_count !== 4'd8)  begin n_fail++; $display("FAIL full_count: got %0d expected 8", out_count); end
    @(posedge clk); #1;
    n_checks = n_checks + 1;
    if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL full_pulse: got %b expected 0", out_valid); end
    drain();
  endtask

  task automatic test_partial();
    logic [VEC_W-1:0] ref_v;
    ref_v = {32'hA, 32'hB, 32'hC, 160'h0};
    send_word(32'hA, 1'b0);
    send_word(32'hB, 1'b0);
    send_word(32'hC, 1'b1);
    n_checks = n_checks + 2;
    if (out_data !== ref_v) begin n_fail++; $display("FAIL part_data: got %h expected %h", out_data, ref_v); end
    if (out_count !== 4'd3) begin n_fail++; $display("FAIL part_count: got %0d expected 3", out_count); end
    for (int i = 0; i < 8; i++) send_word(32'h100 + WIDTH'(i), 1'b0);
    drain();
  endtask

  task automatic test_backpressure();
    logic [VEC_W-1:0] ref_v;
    ref_v = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    out_ready = 1'b0;
    for (int i = 1; i <= 16; i++) send_word(WIDTH'(i), 1'b0);
    for (int c = 0; c < 3; c++) begin
      n_checks = n_checks + 3;
      if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL bp_ready: cycle %0d got %b expected 0", c, in_ready); end
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: cycle %0d got %b expected 1", c, out_valid); end
      if (out_data !== ref_v) begin n_fail++; $display("FAIL bp_stable: cycle %0d got %h expected %h", c, out_data, ref_v); end
      @(posedge clk); #1;
    end
    fork
      send_word(32'd17, 1'b1);
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_back_to_back();
    int lows;
    int c0;
    int dc;
    bit done;
    lows = 0;
    done = 1'b0;
    out_ready = 1'b1;
    c0 = cyc;
    fork
      begin
        for (int i = 0; i < 24; i++) send_word(32'h200 + WIDTH'(i), 1'b0);
        dc = cyc - c0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          if (!done && in_ready !== 1'b1) lows++;
        end
      end
    join
    n_checks = n_checks + 2;
    if (lows != 0) begin n_fail++; $display("FAIL b2b_ready: in_ready low %0d cycles expected 0", lows); end
    if (dc != 24)  begin n_fail++; $display("FAIL b2b_rate: took %0d cycles expected 24", dc); end
    drain();
  endtask

  task automatic test_mid_reset();
    logic [VEC_W-1:0] ref_v;
    ref_v = {32'd9, 32'd10, 32'd11, 32'd12, 32'd13, 32'd14, 32'd15, 32'd16};
    for (int i = 1; i <= 5; i++) send_word(32'h300 + WIDTH'(i), 1'b0);
    rst_n = 1'b0;
    #1;
    n_checks = n_checks + 1;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_valid: got %b expected 0", out_valid); end
    words_q.delete();
    exp_data_q.delete();
    exp_cnt_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 9; i <= 16; i++) send_word(WIDTH'(i), 1'b0);
    n_checks = n_checks + 1;
    if (out_data !== ref_v) begin n_fail++; $display("FAIL mrst_data: got %h expected %h", out_data, ref_v); end
    drain();
  endtask

  task automatic test_last_boundary();
    logic [VEC_W-1:0] ref_v;
    ref_v = {32'd5, 224'h0};
    for (int i = 1; i <= 7; i++) send_word(WIDTH'(i), 1'b0);
    send_word(32'd8, 1'b1);
    send_word(32'd5, 1'b1);
    n_checks = n_checks + 2;
    if (out_data !== ref_v) begin n_fail++; $display("FAIL last_data: got %h expected %h", out_data, ref_v); end
    if (out_count !== 4'd1) begin n_fail++; $display("FAIL last_count: got %0d expected 1", out_count); end
    // in_last without in_valid must not close anything.
    in_last = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_last = 1'b0;
    drain();
    n_checks = n_checks + 1;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL last_idle: got %b expected 0", out_valid); end
  endtask

  initial begin
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    #1;
    test_reset();
    test_full_vector();
    test_partial();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_last_boundary();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sum_operand_packer
`default_nettype wire
